reg_file_stack: RTL and testbench

Parametrised CPU register file with an integrated hardware LIFO stack, successor to the fixed four-entry, 8-bit register block. It provides one write port, two asynchronous read ports, and PUSH/POP operations that move data between the register file and an internal stack. It sits between the instruction decoder and the ALU datapath.

---
 rtl/reg_file_stack_pkg.sv | 19 +
 rtl/reg_file_stack_if.sv | 39 +++
 rtl/reg_file_stack_lifo.sv | 96 +++++++++
 rtl/reg_file_stack.sv | 57 +++++
 tb/tb_reg_file_stack.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/reg_file_stack_pkg.sv
// Shared defaults and the stack operation encoding for the register file / LIFO block.
package reg_file_stack_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int REG_NUM_DEF   = 4;
  localparam int STK_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_SWAP = 2'b11
  } stk_op_e;

  function automatic stk_op_e decode_op(input logic push, input logic pop);
    return stk_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/reg_file_stack_if.sv
// Decoder-side bus of the register file: write port, two read ports, stack control and status.
interface reg_file_stack_if
  import reg_file_stack_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_NUM   = REG_NUM_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF
);
  localparam int AW = $clog2(REG_NUM);
  localparam int CW = $clog2(STK_DEPTH) + 1;

  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;
  logic [AW-1:0]     raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic [AW-1:0]     raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              push;
  logic              pop;
  logic [AW-1:0]     pop_addr;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              ovf;
  logic              unf;
  logic              err_clr;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, push, pop, pop_addr, err_clr,
    input  rdata_a, rdata_b, full, empty, count, ovf, unf
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, push, pop, pop_addr, err_clr,
    output rdata_a, rdata_b, full, empty, count, ovf, unf
  );

endinterface

// File: rtl/reg_file_stack_lifo.sv
// LIFO stack with saturating stack pointer, sticky overflow/underflow flags and a swap operation.
module lifo_stack
  import reg_file_stack_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int PW     = $clog2(DEPTH) + 1,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  stk_op_e           op_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] top_data_o,
  output logic              pop_wr_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [PW-1:0]     count_o,
  output logic              ovf_o,
  output logic              unf_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_en;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     top_idx;

  assign top_idx    = IW'(sp_q - PW'(1));
  assign top_data_o = mem_q[top_idx];
  assign full_o     = (sp_q == PW'(DEPTH));
  assign empty_o    = (sp_q == '0);
  assign count_o    = sp_q;
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;

  always_comb begin
    sp_d     = sp_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    wr_en    = 1'b0;
    wr_idx   = IW'(sp_q);
    pop_wr_o = 1'b0;
    case (op_i)
      OP_PUSH: begin
        if (full_o) ovf_d = 1'b1;
        else begin
          wr_en = 1'b1;
          sp_d  = sp_q + PW'(1);
        end
      end
      OP_POP: begin
        if (empty_o) unf_d = 1'b1;
        else begin
          pop_wr_o = 1'b1;
          sp_d     = sp_q - PW'(1);
        end
      end
      OP_SWAP: begin
        // An empty stack cannot be popped, so the swap degrades to a plain push.
        if (empty_o) begin
          wr_en = 1'b1;
          sp_d  = sp_q + PW'(1);
          unf_d = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_idx   = top_idx;
          pop_wr_o = 1'b1;
        end
      end
      default: ;
    endcase
    if (err_clr_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (wr_en) mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/reg_file_stack.sv
// Register file with two combinational read ports, one write port and PUSH/POP to an internal LIFO.
module reg_file_stack
  import reg_file_stack_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_NUM   = REG_NUM_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_file_stack_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic [DATA_W-1:0] regs_d [REG_NUM];
  logic [DATA_W-1:0] top_data;
  logic              pop_wr;
  stk_op_e           op;

  assign op          = decode_op(bus.push, bus.pop);
  assign bus.rdata_a = regs_q[bus.raddr_a];
  assign bus.rdata_b = regs_q[bus.raddr_b];

  lifo_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (STK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_i        (op),
    .push_data_i (regs_q[bus.raddr_a]),
    .err_clr_i   (bus.err_clr),
    .top_data_o  (top_data),
    .pop_wr_o    (pop_wr),
    .full_o      (bus.full),
    .empty_o     (bus.empty),
    .count_o     (bus.count),
    .ovf_o       (bus.ovf),
    .unf_o       (bus.unf)
  );

  // The write port is applied after the pop so it wins on an address collision.
  always_comb begin
    regs_d = regs_q;
    if (pop_wr) regs_d[bus.pop_addr] = top_data;
    if (bus.we) regs_d[bus.waddr] = bus.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_reg_file_stack.sv
// Directed bench for reg_file_stack: register writes, stack fill/drain, flags, collisions, reset.
module tb_reg_file_stack;

  localparam int DATA_W    = 8;
  localparam int REG_NUM   = 4;
  localparam int STK_DEPTH = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  reg_file_stack_if #(.DATA_W(DATA_W), .REG_NUM(REG_NUM), .STK_DEPTH(STK_DEPTH)) bus ();

  reg_file_stack #(.DATA_W(DATA_W), .REG_NUM(REG_NUM), .STK_DEPTH(STK_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input int a, input logic [7:0] exp);
    bus.raddr_b = 2'(a);
    #1;
    check(tag, 32'(bus.rdata_b), 32'(exp));
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    bus.we = 1'b1; bus.waddr = 2'(a); bus.wdata = d;
    tick();
    idle();
  endtask

  task automatic do_push(input int a);
    bus.push = 1'b1; bus.raddr_a = 2'(a);
    tick();
    idle();
  endtask

  task automatic do_pop(input int a);
    bus.pop = 1'b1; bus.pop_addr = 2'(a);
    tick();
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    bus.waddr = '0; bus.wdata = '0; bus.raddr_a = '0; bus.raddr_b = '0; bus.pop_addr = '0;
    #12;
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    check("rst_unf", 32'(bus.unf), 0);
    check("rst_rdata_a", 32'(bus.rdata_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // write then read
    wr(1, 8'h5A);
    bus.raddr_a = 2'd1;
    #1;
    check("wr_rdata_a", 32'(bus.rdata_a), 32'h5A);
    chk_reg("wr_r0", 0, 8'h00);
    chk_reg("wr_r2", 2, 8'h00);
    chk_reg("wr_r3", 3, 8'h00);

    // fill the stack
    for (int i = 0; i < STK_DEPTH; i++) begin
      do_push(1);
      check($sformatf("fill_count%0d", i), 32'(bus.count), 32'(i + 1));
    end
    check("fill_full", 32'(bus.full), 1);
    check("fill_ovf", 32'(bus.ovf), 0);
    do_push(1);
    check("ovf_set", 32'(bus.ovf), 1);
    check("ovf_count", 32'(bus.count), 8);
    bus.err_clr = 1'b1;
    tick();
    idle();
    check("ovf_clr", 32'(bus.ovf), 0);
    check("ovf_clr_full", 32'(bus.full), 1);

    // drain
    for (int i = 0; i < STK_DEPTH; i++) do_pop(3);
    chk_reg("drain_r3", 3, 8'h5A);
    check("drain_empty", 32'(bus.empty), 1);
    check("drain_unf", 32'(bus.unf), 0);

    // stack order; the push samples reg0 before the same-cycle write
    wr(0, 8'h11);
    bus.push = 1'b1; bus.raddr_a = 2'd0;
    bus.we = 1'b1; bus.waddr = 2'd0; bus.wdata = 8'h22;
    tick();
    idle();
    chk_reg("order_r0", 0, 8'h22);
    do_push(0);
    check("order_count", 32'(bus.count), 2);
    do_pop(3);
    chk_reg("order_pop1", 3, 8'h22);
    do_pop(3);
    chk_reg("order_pop2", 3, 8'h11);
    check("order_empty", 32'(bus.empty), 1);

    // pop while empty
    do_pop(3);
    check("unf_set", 32'(bus.unf), 1);
    chk_reg("unf_r3", 3, 8'h11);
    check("unf_count", 32'(bus.count), 0);
    bus.pop = 1'b1; bus.pop_addr = 2'd3; bus.err_clr = 1'b1;
    tick();
    idle();
    check("clr_prio_unf", 32'(bus.unf), 0);

    // push+pop swap and write-wins collision
    wr(1, 8'h33);
    bus.push = 1'b1; bus.raddr_a = 2'd1;
    bus.we = 1'b1; bus.waddr = 2'd0; bus.wdata = 8'h44;
    tick();
    idle();
    bus.push = 1'b1; bus.pop = 1'b1; bus.raddr_a = 2'd0; bus.pop_addr = 2'd2;
    tick();
    idle();
    chk_reg("swap_r2", 2, 8'h33);
    check("swap_count", 32'(bus.count), 1);
    do_pop(1);
    chk_reg("swap_top", 1, 8'h44);
    do_push(1);
    bus.pop = 1'b1; bus.pop_addr = 2'd2;
    bus.we = 1'b1; bus.waddr = 2'd2; bus.wdata = 8'h99;
    tick();
    idle();
    chk_reg("we_wins_r2", 2, 8'h99);
    check("we_wins_count", 32'(bus.count), 0);

    // swap on empty acts as push and flags underflow
    bus.push = 1'b1; bus.pop = 1'b1; bus.raddr_a = 2'd0; bus.pop_addr = 2'd3;
    tick();
    idle();
    check("swap_empty_count", 32'(bus.count), 1);
    check("swap_empty_unf", 32'(bus.unf), 1);
    chk_reg("swap_empty_r3", 3, 8'h11);
    do_pop(3);
    chk_reg("swap_empty_pop", 3, 8'h44);
    bus.err_clr = 1'b1;
    tick();
    idle();
    check("unf_clr", 32'(bus.unf), 0);

    // reset in the middle of a push burst
    for (int i = 0; i < 5; i++) do_push(0);
    check("burst_count", 32'(bus.count), 5);
    bus.push = 1'b1; bus.raddr_a = 2'd0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(bus.count), 0);
    check("mid_rst_empty", 32'(bus.empty), 1);
    for (int i = 0; i < REG_NUM; i++) chk_reg($sformatf("mid_rst_r%0d", i), i, 8'h00);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_count", 32'(bus.count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
